sdram_rd_arbiter: RTL and testbench
===================================

SDRAM_RD_ARBITER -- requirements
Module: sdram_rd_arbiter

Interface
REQ-001 Parameter ADDR_W, default 25, SDRAM word-address width.
REQ-002 Parameter DATA_W, default 16, SDRAM read data width.
REQ-003 Parameter STARVE_MAX, default 8, consecutive LCD grants allowed while CPU request is pending.
REQ-004 clk  input  1  single clock for all logic; one clock, no other clock domains.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 lcd_req  input  1  LCD pixel-fetch read request, level, held until lcd_ack.
REQ-007 lcd_addr  input  ADDR_W  LCD read address, stable while lcd_req high.
REQ-008 lcd_ack  output  1  one-cycle pulse: lcd_data valid.
REQ-009 lcd_data  output  DATA_W  captured read data for LCD.
REQ-010 cpu_req / cpu_addr / cpu_ack / cpu_data  same directions, widths and meaning as the LCD set, for the ROM/CPU requester.
REQ-011 sdram_rd  output  1  one-cycle read strobe to SDRAM controller.
REQ-012 sdram_addr  output  ADDR_W  read address, held from strobe until data returns.
REQ-013 sdram_data  input  DATA_W  read data from SDRAM controller.
REQ-014 sdram_ready  input  1  one-cycle pulse: sdram_data valid for the outstanding read.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT, DONE; exactly one read outstanding at any time.
REQ-016 IDLE: if any request is pending, latch the winner and its address into sdram_addr and go to ISSUE; otherwise stay.
REQ-017 Fixed priority: LCD wins over CPU when both are pending, unless the starvation rule of REQ-022 applies.
REQ-018 ISSUE: sdram_rd=1 for exactly this one cycle; next state WAIT.
REQ-019 WAIT: on sdram_ready capture sdram_data into the winner's data register and go to DONE; otherwise hold sdram_addr and stay.
REQ-020 DONE: pulse the winner's ack for one cycle; the loser's ack stays 0; return to IDLE.
REQ-021 Minimum latency from request to ack is 4 cycles when sdram_ready arrives in the first WAIT cycle: IDLE, ISSUE, WAIT, DONE.
REQ-022 Starvation counter (width ceil(log2(STARVE_MAX+1))) increments on each LCD grant while cpu_req is high; when it equals STARVE_MAX and cpu_req is high, the next grant goes to CPU.
REQ-023 Counter clears on any CPU grant and whenever cpu_req is low in IDLE; it saturates and never wraps.
REQ-024 lcd_data and cpu_data hold their last captured value until the next ack of the same requester.
REQ-025 sdram_ready outside WAIT is ignored; no state or data change.
REQ-026 A request dropped before its grant is not served; a request dropped after its grant still completes, and the ack is still pulsed.
REQ-027 A request held high through DONE is re-arbitrated in the following IDLE cycle, giving back-to-back service.

Reset
REQ-028 On reset_n low, asynchronously: state IDLE, sdram_rd=0, sdram_addr=0, lcd_ack=0, cpu_ack=0, lcd_data=0, cpu_data=0, starvation counter=0.
REQ-029 Reset asserted mid-transaction abandons the read; a late sdram_ready after release is ignored (REQ-025).

Configuration
REQ-030 Macro SDRAM_ARB_RR_EN defined: replace fixed priority with round-robin; on simultaneous requests, the requester not granted last wins, and the starvation counter is not built.
REQ-031 Macro SDRAM_ARB_RR_EN undefined: fixed LCD priority with the starvation rule (REQ-017, REQ-022, REQ-023).
REQ-032 Round-robin last-grant flag resets to CPU, so LCD wins the first tie.

Verification
REQ-033 lcd_req=1, lcd_addr=0x0000640, sdram_ready 1 cycle after strobe with data 0xA5C3 -> sdram_rd one pulse with addr 0x0000640; lcd_ack pulses at cycle 4; lcd_data=0xA5C3.
REQ-034 lcd_req and cpu_req both held high, STARVE_MAX=8 -> grants LCD x8 then CPU x1, repeating; cpu_ack pulses every 9th transaction.
REQ-035 With SDRAM_ARB_RR_EN defined and both held high -> grants alternate LCD, CPU, LCD, CPU, ...
REQ-036 sdram_ready delayed 5 cycles -> sdram_addr stable for all WAIT cycles; no second sdram_rd; ack one cycle after ready.
REQ-037 reset_n pulsed low during WAIT -> all outputs 0 immediately; a later sdram_ready with 0xFFFF produces no ack and no data change.
REQ-038 cpu_req dropped the cycle after ISSUE -> cpu_ack still pulses once with the returned data.

Source files
------------

// File: rtl/sdram_rd_arbiter_if.sv
// Bus bundle for sdram_rd_arbiter: two read requesters (LCD, CPU) and the
// single-read SDRAM controller port. The arbiter uses the slave modport; the
// environment driving requests and SDRAM responses uses the master modport.
interface sdram_rd_arbiter_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 16
);
  logic              lcd_req;
  logic [ADDR_W-1:0] lcd_addr;
  logic              lcd_ack;
  logic [DATA_W-1:0] lcd_data;

  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_data;

  logic              sdram_rd;
  logic [ADDR_W-1:0] sdram_addr;
  logic [DATA_W-1:0] sdram_data;
  logic              sdram_ready;

  modport slave (
    input  lcd_req, lcd_addr, cpu_req, cpu_addr, sdram_data, sdram_ready,
    output lcd_ack, lcd_data, cpu_ack, cpu_data, sdram_rd, sdram_addr
  );

  modport master (
    output lcd_req, lcd_addr, cpu_req, cpu_addr, sdram_data, sdram_ready,
    input  lcd_ack, lcd_data, cpu_ack, cpu_data, sdram_rd, sdram_addr
  );
endinterface

// File: rtl/sdram_rd_arbiter.sv
// sdram_rd_arbiter: arbitrates LCD and CPU read requests onto a single SDRAM
// read port with exactly one read outstanding (IDLE -> ISSUE -> WAIT -> DONE).
// Default build: LCD has fixed priority, bounded by a starvation counter that
// forces a CPU grant after STARVE_MAX consecutive LCD grants while the CPU waits.
// Optional feature macro SDRAM_ARB_RR_EN: round-robin arbitration instead, and
// the starvation counter is not built.
module sdram_rd_arbiter #(
  parameter int ADDR_W     = 25,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  sdram_rd_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
  typedef enum logic {REQ_LCD, REQ_CPU} req_e;

  state_e            state_q, state_d;
  req_e              winner_q, winner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] lcd_data_q, lcd_data_d;
  logic [DATA_W-1:0] cpu_data_q, cpu_data_d;
  logic              any_req;
  logic              grant_cpu;

`ifdef SDRAM_ARB_RR_EN
  // Set when the most recent grant went to the CPU; resets to CPU so LCD wins the first tie.
  logic last_cpu_q, last_cpu_d;
`else
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  logic [SW-1:0] starve_q, starve_d;
`endif

  assign any_req = bus.lcd_req | bus.cpu_req;

  // Arbitration decision, only consumed in IDLE.
`ifdef SDRAM_ARB_RR_EN
  assign grant_cpu = bus.cpu_req & (~bus.lcd_req | ~last_cpu_q);
`else
  assign grant_cpu = bus.cpu_req & (~bus.lcd_req | (starve_q == STARVE_LIM));
`endif

  // State register: all flops update together, asynchronously cleared.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      winner_q   <= REQ_LCD;
      addr_q     <= '0;
      lcd_data_q <= '0;
      cpu_data_q <= '0;
`ifdef SDRAM_ARB_RR_EN
      last_cpu_q <= 1'b1;
`else
      starve_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      winner_q   <= winner_d;
      addr_q     <= addr_d;
      lcd_data_q <= lcd_data_d;
      cpu_data_q <= cpu_data_d;
`ifdef SDRAM_ARB_RR_EN
      last_cpu_q <= last_cpu_d;
`else
      starve_q   <= starve_d;
`endif
    end
  end

  // Next-state logic: arbitration in IDLE, data capture in WAIT.
  always_comb begin
    // NOTE: every variable gets a hold default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    winner_d   = winner_q;
    addr_d     = addr_q;
    lcd_data_d = lcd_data_q;
    cpu_data_d = cpu_data_q;
`ifdef SDRAM_ARB_RR_EN
    last_cpu_d = last_cpu_q;
`else
    starve_d   = starve_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          winner_d = grant_cpu ? REQ_CPU : REQ_LCD;
          addr_d   = grant_cpu ? bus.cpu_addr : bus.lcd_addr;
          state_d  = ISSUE;
`ifdef SDRAM_ARB_RR_EN
          last_cpu_d = grant_cpu;
`endif
        end
`ifndef SDRAM_ARB_RR_EN
        // Count LCD grants only while the CPU is waiting; saturate at the limit.
        if (!bus.cpu_req || grant_cpu) begin
          starve_d = '0;
        end else if (bus.lcd_req && (starve_q != STARVE_LIM)) begin
          starve_d = starve_q + SW'(1);
        end
`endif
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (bus.sdram_ready) begin
          if (winner_q == REQ_CPU) cpu_data_d = bus.sdram_data;
          else                     lcd_data_d = bus.sdram_data;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: Moore decode of the state register, so reset clears them at once.
  always_comb begin
    bus.sdram_rd   = (state_q == ISSUE);
    bus.sdram_addr = addr_q;
    bus.lcd_ack    = (state_q == DONE) && (winner_q == REQ_LCD);
    bus.cpu_ack    = (state_q == DONE) && (winner_q == REQ_CPU);
    bus.lcd_data   = lcd_data_q;
    bus.cpu_data   = cpu_data_q;
  end

endmodule

// File: tb/tb_sdram_rd_arbiter.sv
// Directed testbench for sdram_rd_arbiter. Inputs change and outputs are
// sampled 1 ns after each rising edge. Honours SDRAM_ARB_RR_EN when defined.
module tb_sdram_rd_arbiter;

  logic clk;
  logic reset_n;
  int   n_cmp = 0;
  int   n_mis = 0;
  logic exp_cpu;

  sdram_rd_arbiter_if #(.ADDR_W(25), .DATA_W(16)) bus ();

  sdram_rd_arbiter #(.ADDR_W(25), .DATA_W(16), .STARVE_MAX(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the strobe, then answer after dly extra WAIT cycles.
  // Returns at the sample point of the DONE cycle.
  task automatic serve(input int dly, input logic [15:0] d);
    int n = 0;
    while (bus.sdram_rd !== 1'b1 && n < 20) begin
      cyc(1);
      n++;
    end
    check("strobe_seen", {31'd0, bus.sdram_rd}, 32'd1);
    cyc(1);
    repeat (dly) cyc(1);
    bus.sdram_ready = 1'b1;
    bus.sdram_data  = d;
    cyc(1);
    bus.sdram_ready = 1'b0;
  endtask

  initial begin
    reset_n         = 1'b0;
    bus.lcd_req     = 1'b0;
    bus.lcd_addr    = '0;
    bus.cpu_req     = 1'b0;
    bus.cpu_addr    = '0;
    bus.sdram_data  = '0;
    bus.sdram_ready = 1'b0;
    cyc(2);

    // Reset state
    check("rst_rd",       {31'd0, bus.sdram_rd}, 32'd0);
    check("rst_addr",     {7'd0, bus.sdram_addr}, 32'd0);
    check("rst_lcd_ack",  {31'd0, bus.lcd_ack}, 32'd0);
    check("rst_cpu_ack",  {31'd0, bus.cpu_ack}, 32'd0);
    check("rst_lcd_data", {16'd0, bus.lcd_data}, 32'd0);
    check("rst_cpu_data", {16'd0, bus.cpu_data}, 32'd0);
    reset_n = 1'b1;
    cyc(1);

    // Basic LCD read, ready in first WAIT cycle: ack in 4th cycle
    bus.lcd_req  = 1'b1;
    bus.lcd_addr = 25'h0000640;
    cyc(1);
    check("b_rd_issue",  {31'd0, bus.sdram_rd}, 32'd1);
    check("b_addr",      {7'd0, bus.sdram_addr}, 32'h640);
    cyc(1);
    check("b_rd_wait",   {31'd0, bus.sdram_rd}, 32'd0);
    bus.sdram_ready = 1'b1;
    bus.sdram_data  = 16'hA5C3;
    cyc(1);
    bus.sdram_ready = 1'b0;
    check("b_lcd_ack",   {31'd0, bus.lcd_ack}, 32'd1);
    check("b_cpu_ack",   {31'd0, bus.cpu_ack}, 32'd0);
    check("b_lcd_data",  {16'd0, bus.lcd_data}, 32'hA5C3);
    bus.lcd_req = 1'b0;
    cyc(1);
    check("b_ack_pulse", {31'd0, bus.lcd_ack}, 32'd0);
    check("b_data_hold", {16'd0, bus.lcd_data}, 32'hA5C3);

    // Stray ready while idle is ignored
    bus.sdram_ready = 1'b1;
    bus.sdram_data  = 16'h1111;
    cyc(1);
    bus.sdram_ready = 1'b0;
    cyc(1);
    check("s_rd",       {31'd0, bus.sdram_rd}, 32'd0);
    check("s_lcd_ack",  {31'd0, bus.lcd_ack}, 32'd0);
    check("s_lcd_data", {16'd0, bus.lcd_data}, 32'hA5C3);
    check("s_cpu_data", {16'd0, bus.cpu_data}, 32'd0);

    // Ready delayed 5 cycles: address held, single strobe
    bus.lcd_req  = 1'b1;
    bus.lcd_addr = 25'h1ABCDEF;
    cyc(1);
    check("d_rd_issue", {31'd0, bus.sdram_rd}, 32'd1);
    cyc(1);
    for (int k = 0; k < 5; k++) begin
      check("d_rd_wait",  {31'd0, bus.sdram_rd}, 32'd0);
      check("d_addr",     {7'd0, bus.sdram_addr}, 32'h1ABCDEF);
      check("d_no_ack",   {31'd0, bus.lcd_ack}, 32'd0);
      cyc(1);
    end
    bus.sdram_ready = 1'b1;
    bus.sdram_data  = 16'h3C3C;
    cyc(1);
    bus.sdram_ready = 1'b0;
    bus.lcd_req     = 1'b0;
    check("d_lcd_ack",  {31'd0, bus.lcd_ack}, 32'd1);
    check("d_lcd_data", {16'd0, bus.lcd_data}, 32'h3C3C);
    cyc(1);

    // CPU request dropped after grant still completes
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 25'h0123456;
    cyc(1);
    check("c_rd_issue", {31'd0, bus.sdram_rd}, 32'd1);
    check("c_addr",     {7'd0, bus.sdram_addr}, 32'h0123456);
    cyc(1);
    bus.cpu_req     = 1'b0;
    bus.sdram_ready = 1'b1;
    bus.sdram_data  = 16'h5A5A;
    cyc(1);
    bus.sdram_ready = 1'b0;
    check("c_cpu_ack",  {31'd0, bus.cpu_ack}, 32'd1);
    check("c_lcd_ack",  {31'd0, bus.lcd_ack}, 32'd0);
    check("c_cpu_data", {16'd0, bus.cpu_data}, 32'h5A5A);
    check("c_lcd_hold", {16'd0, bus.lcd_data}, 32'h3C3C);
    cyc(1);
    check("c_ack_pulse", {31'd0, bus.cpu_ack}, 32'd0);

    // Both requesters held: LCD x8 then CPU (fixed) / alternate (round-robin)
    bus.lcd_req  = 1'b1;
    bus.lcd_addr = 25'h00AAAA0;
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 25'h0555550;
    for (int i = 0; i < 18; i++) begin
      serve(0, 16'h1000 + 16'(i));
`ifdef SDRAM_ARB_RR_EN
      exp_cpu = (i % 2) == 1;
`else
      exp_cpu = (i % 9) == 8;
`endif
      check("p_cpu_ack", {31'd0, bus.cpu_ack}, {31'd0, exp_cpu});
      check("p_lcd_ack", {31'd0, bus.lcd_ack}, {31'd0, ~exp_cpu});
      check("p_addr", {7'd0, bus.sdram_addr}, exp_cpu ? 32'h0555550 : 32'h00AAAA0);
      check("p_data", {16'd0, exp_cpu ? bus.cpu_data : bus.lcd_data}, 32'h1000 + i);
    end
    bus.lcd_req = 1'b0;
    bus.cpu_req = 1'b0;
    cyc(1);

    // Reset during WAIT abandons the read; late ready is ignored
    bus.lcd_req  = 1'b1;
    bus.lcd_addr = 25'h0000100;
    cyc(2);
    #1;
    reset_n     = 1'b0;
    bus.lcd_req = 1'b0;
    #1;
    check("r_rd",       {31'd0, bus.sdram_rd}, 32'd0);
    check("r_addr",     {7'd0, bus.sdram_addr}, 32'd0);
    check("r_lcd_ack",  {31'd0, bus.lcd_ack}, 32'd0);
    check("r_cpu_ack",  {31'd0, bus.cpu_ack}, 32'd0);
    check("r_lcd_data", {16'd0, bus.lcd_data}, 32'd0);
    check("r_cpu_data", {16'd0, bus.cpu_data}, 32'd0);
    cyc(1);
    reset_n = 1'b1;
    cyc(1);
    bus.sdram_ready = 1'b1;
    bus.sdram_data  = 16'hFFFF;
    cyc(1);
    bus.sdram_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("r_late_ack",  {31'd0, bus.lcd_ack | bus.cpu_ack}, 32'd0);
      check("r_late_data", {16'd0, bus.lcd_data | bus.cpu_data}, 32'd0);
      check("r_late_rd",   {31'd0, bus.sdram_rd}, 32'd0);
      cyc(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
